// File: rtl/ysyx_22041207_axi_pkg.sv
// Shared types and constants for the ysyx_22041207 read responder.
// Optional alignment check is enabled by YSYX_22041207_RD_ALIGN_CHK_EN.
package ysyx_22041207_axi_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } rd_state_e;

   localparam logic [7:0] SIZE_B = 8'h01;
   localparam logic [7:0] SIZE_H = 8'h03;
   localparam logic [7:0] SIZE_W = 8'h0F;
   localparam logic [7:0] SIZE_D = 8'hFF;

   function automatic logic [63:0] align8(input logic [63:0] a);
      return {a[63:3], 3'b000};
   endfunction

   // Only the three natural power-of-two lane masks carry an alignment rule.
   function automatic logic misaligned(input logic [63:0] a,
                                       input logic [7:0]  s);
      logic w_bad;
      w_bad = 1'b0;
      unique case (s)
         SIZE_H:  w_bad = (a[0] != 1'b0);
         SIZE_W:  w_bad = (a[1:0] != 2'b00);
         SIZE_D:  w_bad = (a[2:0] != 3'b000);
         default: w_bad = 1'b0;
      endcase
      return w_bad;
   endfunction

endpackage

// File: rtl/ysyx_22041207_rd_responder_if.sv
// Read request/response handshake bundle between initiator and responder.
// rx_r_err exists only when YSYX_22041207_RD_ALIGN_CHK_EN is defined.
interface ysyx_22041207_rd_responder_if;

   logic        rx_r_valid_i;
   logic        rx_r_ready_o;
   logic [63:0] rx_r_addr_i;
   logic [7:0]  rx_r_size_i;
   logic [63:0] rx_data_read_o;
   logic        rx_data_valid;
   logic        rx_data_ready;
`ifdef YSYX_22041207_RD_ALIGN_CHK_EN
   logic        rx_r_err;

   modport master (
      output rx_r_valid_i, rx_r_addr_i, rx_r_size_i, rx_data_ready,
      input  rx_r_ready_o, rx_data_read_o, rx_data_valid, rx_r_err
   );

   modport slave (
      input  rx_r_valid_i, rx_r_addr_i, rx_r_size_i, rx_data_ready,
      output rx_r_ready_o, rx_data_read_o, rx_data_valid, rx_r_err
   );
`else
   modport master (
      output rx_r_valid_i, rx_r_addr_i, rx_r_size_i, rx_data_ready,
      input  rx_r_ready_o, rx_data_read_o, rx_data_valid
   );

   modport slave (
      input  rx_r_valid_i, rx_r_addr_i, rx_r_size_i, rx_data_ready,
      output rx_r_ready_o, rx_data_read_o, rx_data_valid
   );
`endif

endinterface

// File: rtl/ysyx_22041207_byte_mask.sv
// Zeroes every byte of a 64-bit beat whose lane-mask bit is clear.
module ysyx_22041207_byte_mask (
   input  logic [63:0] i_data,
   input  logic [7:0]  i_mask,
   output logic [63:0] o_data
);

   for (genvar g = 0; g < 8; g++) begin : g_lane
      assign o_data[g*8 +: 8] = i_data[g*8 +: 8] & {8{i_mask[g]}};
   end

endmodule

// File: rtl/ysyx_22041207_rd_responder.sv
// Single-outstanding read responder: IDLE -> ISSUE -> WAIT -> RESP.
// Define YSYX_22041207_RD_ALIGN_CHK_EN to add rx_r_err alignment checking.
module ysyx_22041207_rd_responder
   import ysyx_22041207_axi_pkg::*;
#(
   parameter int LATENCY = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   ysyx_22041207_rd_responder_if.slave   rx,
   output logic                          mem_en,
   output logic [63:0]                   mem_addr,
   input  logic [63:0]                   mem_rdata
);

   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   rd_state_e   r_state;
   logic        r_ready;
   logic        r_valid;
   logic [63:0] r_data;
   logic [7:0]  r_size;
   logic [3:0]  r_cnt;
   logic        r_mem_en;
   logic [63:0] r_mem_addr;
   logic [63:0] w_masked;
`ifdef YSYX_22041207_RD_ALIGN_CHK_EN
   logic        r_err;
`endif

   ysyx_22041207_byte_mask u_mask (
      .i_data (mem_rdata),
      .i_mask (r_size),
      .o_data (w_masked)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_ready    <= 1'b0;
         r_valid    <= 1'b0;
         r_data     <= '0;
         r_size     <= '0;
         r_cnt      <= '0;
         r_mem_en   <= 1'b0;
         r_mem_addr <= '0;
`ifdef YSYX_22041207_RD_ALIGN_CHK_EN
         r_err      <= 1'b0;
`endif
      end else begin
         unique case (r_state)
            S_IDLE: begin
               // ready rises one edge after reset release
               if (!r_ready) begin
                  r_ready <= 1'b1;
               end else if (rx.rx_r_valid_i) begin
                  r_ready <= 1'b0;
                  r_size  <= rx.rx_r_size_i;
`ifdef YSYX_22041207_RD_ALIGN_CHK_EN
                  if (misaligned(rx.rx_r_addr_i, rx.rx_r_size_i)) begin
                     r_state <= S_RESP;
                     r_valid <= 1'b1;
                     r_err   <= 1'b1;
                  end else begin
                     r_state    <= S_ISSUE;
                     r_mem_en   <= 1'b1;
                     r_mem_addr <= align8(rx.rx_r_addr_i);
                  end
`else
                  r_state    <= S_ISSUE;
                  r_mem_en   <= 1'b1;
                  r_mem_addr <= align8(rx.rx_r_addr_i);
`endif
               end
            end
            S_ISSUE: begin
               r_mem_en   <= 1'b0;
               r_mem_addr <= '0;
               r_cnt      <= '0;
               r_state    <= S_WAIT;
            end
            S_WAIT: begin
               if (r_cnt == LAT_M1) begin
                  r_data  <= w_masked;
                  r_valid <= 1'b1;
                  r_cnt   <= '0;
                  r_state <= S_RESP;
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            S_RESP: begin
               if (rx.rx_data_ready) begin
                  r_valid <= 1'b0;
                  r_data  <= '0;
                  r_ready <= 1'b1;
                  r_state <= S_IDLE;
`ifdef YSYX_22041207_RD_ALIGN_CHK_EN
                  r_err   <= 1'b0;
`endif
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign rx.rx_r_ready_o   = r_ready;
   assign rx.rx_data_valid  = r_valid;
   assign rx.rx_data_read_o = r_data;
   assign mem_en            = r_mem_en;
   assign mem_addr          = r_mem_addr;
`ifdef YSYX_22041207_RD_ALIGN_CHK_EN
   assign rx.rx_r_err       = r_err;
`endif

endmodule
